// File: rtl/adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe_if
// Purpose  : Bundle of handshake and data signals between an operand source
//            (master) and the pipelined adder (slave).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   in_valid  / in_ready   operand handshake (master -> slave / slave -> master)
//   in1, in2               operands, WIDTH bits
//   out_valid / out_ready  result handshake (slave -> master / master -> slave)
//   out, out_cout          sum modulo 2^WIDTH and its unsigned carry-out
//   txn_cnt                count of accepted operand pairs, CNT_W bits
//   out_ovf, ovf_cnt       signed-overflow flag and saturating count of
//                          retired overflowing results
//                          (only present with ADDER_PIPE_OVF_EN defined)
// ============================================================================
interface adder_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_cout;
    logic [CNT_W-1:0] txn_cnt;
`ifdef ADDER_PIPE_OVF_EN
    logic             out_ovf;
    logic [CNT_W-1:0] ovf_cnt;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, out_cout, txn_cnt, out_ovf, ovf_cnt
    );
    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, out_cout, txn_cnt, out_ovf, ovf_cnt
    );
`else
    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, out_cout, txn_cnt
    );
    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, out_cout, txn_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Purpose  : Pipelined WIDTH-bit adder. Operands are registered on accept,
//            then each of STAGES ranks adds one WIDTH/STAGES-bit slice and
//            hands its carry to the next rank. A result accepted at posedge N
//            is presented after posedge N+STAGES. The whole pipe freezes
//            while the output is valid and not taken.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH   operand/result width, divisible by STAGES
//   STAGES  number of adder ranks (1, 2 or 4); equals latency in cycles
//   CNT_W   width of the transaction (and overflow) counters
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   bus     adder_pipe_if.slave: in_valid/in_ready/in1/in2,
//           out_valid/out_ready/out/out_cout, txn_cnt
// Optional feature macro: ADDER_PIPE_OVF_EN
//   adds bus.out_ovf (signed overflow travelling with its result) and
//   bus.ovf_cnt (saturating count of retired overflowing results)
// ============================================================================
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    adder_pipe_if.slave bus
);

    localparam int SLICE = WIDTH / STAGES;

    if ((STAGES != 1 && STAGES != 2 && STAGES != 4) || (WIDTH % STAGES != 0)) begin : g_param_check
        $error("adder_pipe: illegal WIDTH/STAGES combination");
    end

    // ------------------------------------------------------------------------
    // Handshake: a single global stall freezes every rank, bubbles included.
    // ------------------------------------------------------------------------
    logic stall;
    logic accept;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign accept       = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;

    // ------------------------------------------------------------------------
    // Capture rank: operands only load on accept; the valid bit advances on
    // every non-stalled cycle so an idle input becomes a bubble.
    // ------------------------------------------------------------------------
    logic             cap_vld_q;
    logic [WIDTH-1:0] cap_a_q;
    logic [WIDTH-1:0] cap_b_q;

    // ------------------------------------------------------------------------
    // Adder ranks. Rank k holds the full operands (upper slices still to be
    // added), the partial sum with slices 0..k filled in, and the carry out
    // of slice k.
    // ------------------------------------------------------------------------
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] cry_q;
    logic [STAGES-1:0] cry_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [SLICE:0]   part;

        if (k == 0) begin : g_head
            assign a_in = cap_a_q;
            assign b_in = cap_b_q;
            assign s_in = '0;
            assign c_in = 1'b0;
            assign v_in = cap_vld_q;
        end else begin : g_body
            assign a_in = opa_q[k-1];
            assign b_in = opb_q[k-1];
            assign s_in = sum_q[k-1];
            assign c_in = cry_q[k-1];
            assign v_in = vld_q[k-1];
        end

        assign part = {1'b0, a_in[k*SLICE +: SLICE]}
                    + {1'b0, b_in[k*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, c_in};

        // Slices above k are still zero in s_in, so OR-ing the new slice in
        // place leaves the already finished lower slices untouched.
        assign opa_d[k] = a_in;
        assign opb_d[k] = b_in;
        assign sum_d[k] = s_in | (WIDTH'(part[SLICE-1:0]) << (k * SLICE));
        assign cry_d[k] = part[SLICE];
        assign vld_d[k] = v_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q <= 1'b0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
            vld_q     <= '0;
            cry_q     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            if (!stall) begin
                cap_vld_q <= bus.in_valid;
                vld_q     <= vld_d;
                cry_q     <= cry_d;
                for (int k = 0; k < STAGES; k++) begin
                    opa_q[k] <= opa_d[k];
                    opb_q[k] <= opb_d[k];
                    sum_q[k] <= sum_d[k];
                end
            end
            if (accept) begin
                cap_a_q <= bus.in1;
                cap_b_q <= bus.in2;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accepted-transfer counter, wraps modulo 2^CNT_W.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] txn_cnt_q;
    logic [CNT_W-1:0] txn_cnt_d;

    assign txn_cnt_d = accept ? txn_cnt_q + CNT_W'(1) : txn_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out       = sum_q[STAGES-1];
    assign bus.out_cout  = cry_q[STAGES-1];
    assign bus.txn_cnt   = txn_cnt_q;

`ifdef ADDER_PIPE_OVF_EN
    // ------------------------------------------------------------------------
    // Signed overflow is decided in the last rank, where the top slice (and
    // with it both operand sign bits and the final sum sign) is produced.
    // ------------------------------------------------------------------------
    logic             ovf_q;
    logic             ovf_d;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_d;

    assign ovf_d = (opa_d[STAGES-1][WIDTH-1] == opb_d[STAGES-1][WIDTH-1])
                && (sum_d[STAGES-1][WIDTH-1] != opa_d[STAGES-1][WIDTH-1]);

    // Saturating: stops at all-ones instead of wrapping.
    assign ovf_cnt_d = (bus.out_valid && bus.out_ready && ovf_q && !(&ovf_cnt_q))
                     ? ovf_cnt_q + CNT_W'(1) : ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            if (!stall) begin
                ovf_q <= ovf_d;
            end
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign bus.out_ovf = ovf_q;
    assign bus.ovf_cnt = ovf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe
// Purpose  : Self-checking bench for adder_pipe: vector table with exact
//            latency checks, hand-written multi-cycle sequences and a random
//            phase compared against an arithmetic reference scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    function automatic res_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t         r;
        logic [WIDTH:0] wide;
        longint       ss;
        wide   = {1'b0, a} + {1'b0, b};
        r.sum  = wide[WIDTH-1:0];
        r.cout = wide[WIDTH];
        ss     = longint'($signed(a)) + longint'($signed(b));
        r.ovf  = (ss > SMAX) || (ss < SMIN);
        return r;
    endfunction

    res_t             sb_q[$];
    logic [CNT_W-1:0] m_txn;
`ifdef ADDER_PIPE_OVF_EN
    logic [CNT_W-1:0] m_ovf;
`endif
    logic             prev_ok;
    logic             prev_stall;
    logic             prev_vld;
    logic             prev_cout;
    logic [WIDTH-1:0] prev_out;

    // Monitor at negedge: inputs are stable, and what is seen here is what
    // the next rising edge will act on.
    always @(negedge clk) begin : mon
        res_t e;
        if (rst !== 1'b0) begin
            sb_q.delete();
            m_txn   = '0;
`ifdef ADDER_PIPE_OVF_EN
            m_ovf   = '0;
`endif
            prev_ok = 1'b0;
        end else begin
            chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            chk("txn_cnt_track", bus.txn_cnt, m_txn);
`ifdef ADDER_PIPE_OVF_EN
            chk("ovf_cnt_track", bus.ovf_cnt, m_ovf);
`endif
            if (prev_ok && prev_stall) begin
                chk("hold_valid", bus.out_valid, prev_vld);
                chk("hold_out", bus.out, prev_out);
                chk("hold_cout", bus.out_cout, prev_cout);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_out", bus.out, e.sum);
                    chk("sb_cout", bus.out_cout, e.cout);
`ifdef ADDER_PIPE_OVF_EN
                    chk("sb_ovf", bus.out_ovf, e.ovf);
                    if (e.ovf && m_ovf != '1) m_ovf = m_ovf + 1'b1;
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(ref_add(bus.in1, bus.in2));
                m_txn = m_txn + 1'b1;
            end
            prev_ok    = 1'b1;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_vld   = bus.out_valid;
            prev_out   = bus.out;
            prev_cout  = bus.out_cout;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Returns just after the edge on which the pair was accepted.
    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int w;
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("push_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    vec_t             tbl[10];
    logic [WIDTH-1:0] got[$];
    int               idx[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ovf_cnt;
        bit seen;

        tbl[0] = '{32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
        tbl[1] = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{32'd3,         32'd4,         32'd7,         1'b0, 1'b0};
        tbl[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        tbl[8] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b1;

        // ---- reset state ----
        do_reset();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out", bus.out, 32'h0);
        chk("rst_out_cout", bus.out_cout, 1'b0);
        chk("rst_txn_cnt", bus.txn_cnt, 16'h0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef ADDER_PIPE_OVF_EN
        chk("rst_out_ovf", bus.out_ovf, 1'b0);
        chk("rst_ovf_cnt", bus.ovf_cnt, 16'h0);
`endif

        // ---- vector table with exact latency ----
        exp_ovf_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            push(tbl[i].a, tbl[i].b);
            for (int s = 0; s < STAGES; s++) begin
                chk("lat_early_valid", bus.out_valid, 1'b0);
                tick();
            end
            chk("lat_valid", bus.out_valid, 1'b1);
            chk("tbl_out", bus.out, tbl[i].sum);
            chk("tbl_cout", bus.out_cout, tbl[i].cout);
`ifdef ADDER_PIPE_OVF_EN
            chk("tbl_ovf", bus.out_ovf, tbl[i].ovf);
            if (tbl[i].ovf) exp_ovf_cnt++;
`endif
            tick();
            chk("lat_single_cycle", bus.out_valid, 1'b0);
`ifdef ADDER_PIPE_OVF_EN
            chk("tbl_ovf_cnt", bus.ovf_cnt, exp_ovf_cnt[CNT_W-1:0]);
`endif
        end
        chk("tbl_txn_cnt", bus.txn_cnt, 16'd10);

        // ---- back-to-back pushes ----
        do_reset();
        got.delete();
        idx.delete();
        for (int c = 0; c < 8 + STAGES + 3; c++) begin
            if (c < 8) begin
                bus.in_valid = 1'b1;
                bus.in1      = c;
                bus.in2      = 2 * c;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (bus.out_valid === 1'b1) begin
                got.push_back(bus.out);
                idx.push_back(c);
            end
        end
        chk("b2b_count", got.size(), 8);
        if (got.size() == 8) begin
            chk("b2b_no_gaps", idx[7] - idx[0], 7);
            chk("b2b_first_cycle", idx[0], STAGES);
            for (int i = 0; i < 8; i++) chk("b2b_value", got[i], 3 * i);
        end
        chk("b2b_txn_cnt", bus.txn_cnt, 16'd8);

        // ---- backpressure ----
        do_reset();
        bus.out_ready = 1'b0;
        push(32'd100, 32'd1);
        push(32'd200, 32'd2);
        push(32'hFFFF_FFF0, 32'h20);
        chk("bp_valid", bus.out_valid, 1'b1);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        chk("bp_out_first", bus.out, 32'd101);
        repeat (3) tick();
        chk("bp_hold_out", bus.out, 32'd101);
        chk("bp_hold_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid === 1'b1) got.push_back(bus.out);
            tick();
        end
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_order0", got[0], 32'd101);
            chk("bp_order1", got[1], 32'd202);
            chk("bp_order2", got[2], 32'h10);
        end
        chk("bp_txn_cnt", bus.txn_cnt, 16'd3);

        // ---- reset mid-flight ----
        do_reset();
        push(32'd1, 32'd2);
        push(32'd3, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_txn_cnt", bus.txn_cnt, 16'h0);
        seen = 1'b0;
        for (int c = 0; c < STAGES + 4; c++) begin
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("mid_no_output", seen, 1'b0);

        // ---- randomized traffic against the scoreboard ----
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in1       = pick();
            bus.in2       = pick();
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (STAGES + 4) tick();
        @(negedge clk);
        #1;
        chk("rand_drained", sb_q.size(), 0);
        chk("rand_txn_cnt", bus.txn_cnt, m_txn);
        chk("rand_idle_valid", bus.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
